rca_seq_adder_ctrl: RTL and testbench

Word-serial add/subtract sequencer built around one shared RCA4 4-bit ripple-carry slice.
- Accepts WIDTH-bit operands over a valid/ready handshake.
- Drives the slice one nibble per clock, LSB nibble first, and holds the inter-nibble carry in a register.
- Presents the WIDTH-bit result with carry and signed-overflow flags over a second valid/ready handshake.
- Used where area matters more than latency: one RCA4 instance replaces a full-width adder.

---
 rtl/rca_seq_adder_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rca_seq_adder_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_adder_ctrl.sv
// Word-serial add/subtract sequencer.
// A single 4-bit ripple-carry slice (rca4) is time-shared across the operand
// width, one nibble per clock, LSB nibble first, with the inter-nibble carry
// held in a register. Operands and results use valid/ready handshakes.

// 4-bit ripple-carry adder slice.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    // Ripple the carry through four full adders.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

module rca_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state_q,     state_d;
    logic [NSLICE-1:0][3:0]  op_a_q,      op_a_d;
    logic [NSLICE-1:0][3:0]  op_b_q,      op_b_d;
    logic [NSLICE-1:0][3:0]  result_q,    result_d;
    logic [IDX_W-1:0]        idx_q,       idx_d;
    logic                    carry_q,     carry_d;
    logic                    carry_out_q, carry_out_d;
    logic                    overflow_q,  overflow_d;
    logic                    in_ready_q,  in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q,      busy_d;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_s;
    logic       slice_cout;

    // Two's-complement overflow: operands agree in sign, sum disagrees.
    // b_msb is the sign of the B actually added (already inverted for sub).
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign slice_a = op_a_q[idx_q];
    assign slice_b = op_b_q[idx_q];

    rca4 u_rca4 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                    op_a_d     = op_a;
                    op_b_d     = sub ? ~op_b : op_b;
                    carry_d    = sub;
                    idx_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                result_d[idx_q] = slice_s;
                carry_d         = slice_cout;
                idx_d           = idx_q + 1'b1;
                if (idx_q == IDX_W'(NSLICE - 1)) begin
                    carry_out_d = slice_cout;
                    overflow_d  = signed_ovf(op_a_q[NSLICE-1][3],
                                             op_b_q[NSLICE-1][3], slice_s[3]);
                    idx_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
// Self-checking bench for rca_seq_adder_ctrl (WIDTH=16).
// A transaction-level model (queue of expected results computed with plain
// integer arithmetic) is compared against the DUT on every falling edge.
module tb_rca_seq_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   acc_hist[$];

    always #5 clk = ~clk;

    rca_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // Reference arithmetic: unsigned sum/difference for result and carry,
    // signed integer range test for overflow.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] r,
                                  output logic c, output logic o);
        int ua, ub, sa, sb, full, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!s) begin
            full = ua + ub;
            sr   = sa + sb;
            c    = (full >= 65536);
        end else begin
            full = ua - ub;
            sr   = sa - sb;
            c    = (ua >= ub);
        end
        r = full[W-1:0];
        o = (sr > 32767) || (sr < -32768);
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic s, input int acc);
        exp_t e;
        model(a, b, s, e.r, e.c, e.o);
        e.acc = acc;
        return e;
    endfunction

    // Result is due NSLICE(=4) edges after the accepting edge.
    function automatic bit exp_out_valid();
        if (q.size() == 0) return 1'b0;
        return (cyc - q[0].acc) >= 5;
    endfunction

    // Model update on each rising edge: accept when idle, retire on handshake.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (in_valid) begin
                q.push_back(make_exp(op_a, op_b, sub, cyc));
                acc_hist.push_back(cyc);
            end
        end else if (exp_out_valid() && out_ready) begin
            void'(q.pop_front());
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(exp_out_valid()));
            if (exp_out_valid()) begin
                chk("result", 32'(result), 32'(q[0].r));
                chk("carry_out", 32'(carry_out), 32'(q[0].c));
                chk("overflow", 32'(overflow), 32'(q[0].o));
            end
        end
    end

    task automatic pin(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo);
        logic [W-1:0] r;
        logic c, o;
        model(a, b, s, r, c, o);
        chk("model_result", 32'(r), 32'(er));
        chk("model_carry", 32'(c), 32'(ec));
        chk("model_ovf", 32'(o), 32'(eo));
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_timeout("accept");
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = t;
                break;
            end
        end
        if (lat < 0) fail_timeout("out_valid");
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        int lat;
        op_a     = a;
        op_b     = b;
        sub      = s;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        sub      = ~s;
        wait_out(lat);
        chk("latency", 32'(lat), 32'd4);
        chk("lit_result", 32'(result), 32'(er));
        chk("lit_carry", 32'(carry_out), 32'(ec));
        chk("lit_ovf", 32'(overflow), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b1;

        pin(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        pin(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        pin(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        pin(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        do_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure in DONE with a new request pending.
        out_ready = 1'b0;
        op_a      = 16'h1111;
        op_b      = 16'h2222;
        sub       = 1'b0;
        in_valid  = 1'b1;
        wait_accept();
        op_a = 16'hAAAA;
        op_b = 16'h0001;
        wait_out(lat);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(result), 32'h3333);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat);
        chk("bp_next_latency", 32'(lat), 32'd4);
        chk("bp_next_result", 32'(result), 32'hAAAB);
        @(posedge clk);
        #1;

        // Reset while the nibble index is 2.
        op_a     = 16'h0FFF;
        op_b     = 16'h0001;
        sub      = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        do_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        // Back-to-back random traffic with in_valid held high.
        acc_hist.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            sub      = 1'($urandom);
            in_valid = 1'b1;
            wait_accept();
        end
        in_valid = 1'b0;
        begin
            bit drained = 1'b0;
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (q.size() == 0) begin
                    drained = 1'b1;
                    break;
                end
            end
            if (!drained) fail_timeout("drain");
        end
        chk("b2b_count", 32'(acc_hist.size()), 32'd20);
        for (int i = 1; i < acc_hist.size(); i++)
            chk("b2b_spacing", 32'(acc_hist[i] - acc_hist[i-1]), 32'd6);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
